// File: rtl/mem_stage.sv
// Memory-access stage: RV32I loads and stores over a req/gnt/rvalid data port.
// Non-memory instructions pass straight through to a registered writeback bundle.
module mem_stage (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] result_i,
  input  logic [31:0] rs2_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misaligned_o
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [1:0]  lane_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        wb_valid_q;
  logic        wb_en_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        misaligned_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  lane;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        pass_wb_en;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  // Bits above funct3 carry no meaning for this stage.
  logic unused_instr;
  assign unused_instr = ^instr_i[31:15];

  // Decode the incoming instruction: access kind, alignment, lane enables and write data.
  always_comb begin
    opcode   = instr_i[6:0];
    funct3   = instr_i[14:12];
    rd       = instr_i[11:7];
    lane     = result_i[1:0];
    // Unsupported funct3 encodings fall back to the pass-through path.
    is_load  = (opcode == OpLoad) && (funct3 != 3'b011) && (funct3 != 3'b110) &&
               (funct3 != 3'b111);
    is_store = (opcode == OpStore) && !funct3[2] && (funct3[1:0] != 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                 ((funct3[1:0] == 2'b10) && (lane != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << lane;
        wdata = {2{rs2_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2_i;
      end
    endcase
    pass_wb_en = (rd != 5'd0) && (opcode != OpBranch) && (opcode != OpStore) &&
                 (opcode != OpLoad);
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    rbyte = mem_rdata_i[{lane_q, 3'b000} +: 8];
    rhalf = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_data = {24'h000000, rbyte};
      3'b101:  load_data = {16'h0000, rhalf};
      default: load_data = mem_rdata_i;
    endcase
  end

  // Stage FSM together with the registered memory-port and writeback outputs.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= StIdle;
      funct3_q     <= 3'b000;
      rd_q         <= 5'd0;
      lane_q       <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      wb_valid_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      // Writeback and misaligned are single-cycle pulses.
      wb_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            if ((is_load || is_store) && misaligned) begin
              wb_valid_q   <= 1'b1;
              wb_en_q      <= 1'b0;
              wb_rd_q      <= rd;
              wb_data_q    <= result_i;
              misaligned_q <= 1'b1;
            end else if (is_load || is_store) begin
              state_q     <= StReq;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_be_q    <= be;
              mem_addr_q  <= {result_i[31:2], 2'b00};
              mem_wdata_q <= wdata;
              funct3_q    <= funct3;
              rd_q        <= rd;
              lane_q      <= lane;
            end else begin
              wb_valid_q <= 1'b1;
              wb_en_q    <= pass_wb_en;
              wb_rd_q    <= rd;
              wb_data_q  <= result_i;
            end
          end
        end
        StReq: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state_q    <= StIdle;
              wb_valid_q <= 1'b1;
              wb_en_q    <= 1'b0;
              wb_rd_q    <= rd_q;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            state_q    <= StIdle;
            wb_valid_q <= 1'b1;
            wb_en_q    <= (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= load_data;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o      = (state_q == StIdle);
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_en_o      = wb_en_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized run against a byte-level memory model.
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic [31:0] result_i;
  logic [31:0] rs2_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Word memory served to the DUT, and the byte-level reference the expectations come from.
  logic [31:0] phys[16];
  logic [7:0]  ref_bytes[64];

  mem_stage dut (
    .clk          (clk),
    .rstn_i       (rstn_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .instr_i      (instr_i),
    .result_i     (result_i),
    .rs2_i        (rs2_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_en_o      (wb_en_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .misaligned_o (misaligned_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd);
    logic [31:0] hi;
    hi = $urandom;
    return {hi[31:15], f3, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until the stage takes it (bounded).
  task automatic send(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] st);
    int k;
    k = 0;
    valid_i  = 1'b1;
    instr_i  = ins;
    result_i = res;
    rs2_i    = st;
    while (!ready_o && k < 50) begin
      tick();
      k++;
    end
    n_total++;
    if (ready_o !== 1'b1)
      $display("FAIL send_ready: ready_o=%b after %0d cycles, required 1", ready_o, k);
    else n_pass++;
    tick();
    valid_i  = 1'b0;
    instr_i  = $urandom;
    result_i = $urandom;
    rs2_i    = $urandom;
  endtask

  // Drive one memory transaction as the data memory; snap = {req,we,be,addr,wdata} at first REQ.
  task automatic run_mem(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] st,
                         input int gd, input int rvd, output logic [69:0] snap,
                         output logic stable, output logic busy, output logic req_after);
    logic [69:0] cur;
    send(ins, res, st);
    snap   = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
    stable = 1'b1;
    busy   = !ready_o;
    for (int k = 0; k < gd; k++) begin
      tick();
      cur = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
      if (cur !== snap) stable = 1'b0;
      if (ready_o) busy = 1'b0;
    end
    mem_gnt_i = 1'b1;
    if (mem_we_o === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) phys[mem_addr_o[5:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
    end
    tick();
    mem_gnt_i = 1'b0;
    if (ins[6:0] == OP_LOAD) begin
      for (int k = 0; k < rvd; k++) begin
        if (ready_o) busy = 1'b0;
        tick();
      end
      if (ready_o) busy = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = phys[snap[37:34]];
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
    req_after = mem_req_o;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    n_total++;
    if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b, required 1", ready_o);
    else n_pass++;
    n_total++;
    if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 70'h0)
      $display("FAIL reset_mem: got req=%b we=%b be=%h addr=%h wdata=%h, required all 0",
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
    else n_pass++;
    n_total++;
    if ({wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, misaligned_o} !== 40'h0)
      $display("FAIL reset_wb: got valid=%b en=%b rd=%0d data=%h mis=%b, required all 0",
               wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, misaligned_o);
    else n_pass++;
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    send(mk(OP_ALU, 3'b000, 5'd5), 32'h1234, $urandom);
    n_total++;
    if ({wb_valid_o, wb_en_o, wb_rd_o, wb_data_o} !== {1'b1, 1'b1, 5'd5, 32'h00001234})
      $display("FAIL add_x5: got valid=%b en=%b rd=%0d data=%h, required 1 1 5 00001234",
               wb_valid_o, wb_en_o, wb_rd_o, wb_data_o);
    else n_pass++;
    send(mk(OP_ALU, 3'b000, 5'd0), 32'h1234, $urandom);
    n_total++;
    if ({wb_valid_o, wb_en_o} !== 2'b10)
      $display("FAIL add_x0: got valid=%b en=%b, required 1 0", wb_valid_o, wb_en_o);
    else n_pass++;
    tick();
    n_total++;
    if ({wb_valid_o, wb_data_o} !== {1'b0, 32'h00001234})
      $display("FAIL wb_hold: got valid=%b data=%h, required 0 00001234", wb_valid_o, wb_data_o);
    else n_pass++;
    send(mk(OP_BRANCH, 3'b001, 5'd7), 32'h55, $urandom);
    n_total++;
    if ({wb_valid_o, wb_en_o} !== 2'b10)
      $display("FAIL branch_no_wb: got valid=%b en=%b, required 1 0", wb_valid_o, wb_en_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send(mk(OP_IMM, 3'b000, 5'd3), 32'h11, $urandom);
    n_total++;
    if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd3, 32'h11})
      $display("FAIL b2b_first: got valid=%b rd=%0d data=%h, required 1 3 00000011",
               wb_valid_o, wb_rd_o, wb_data_o);
    else n_pass++;
    n_total++;
    if (ready_o !== 1'b1) $display("FAIL b2b_ready: got %b, required 1", ready_o);
    else n_pass++;
    send(mk(OP_LUI, 3'b000, 5'd4), 32'h22, $urandom);
    n_total++;
    if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd4, 32'h22})
      $display("FAIL b2b_second: got valid=%b rd=%0d data=%h, required 1 4 00000022",
               wb_valid_o, wb_rd_o, wb_data_o);
    else n_pass++;
  endtask

  task automatic test_store();
    logic [69:0] snap;
    logic stable, busy, req_after;
    run_mem(mk(OP_STORE, 3'b000, 5'd9), 32'h1003, 32'hAABBCCDD, 3, 0, snap, stable, busy,
            req_after);
    n_total++;
    if (snap !== {1'b1, 1'b1, 4'b1000, 32'h1000, 32'hDDDDDDDD})
      $display("FAIL sb_port: got req=%b we=%b be=%b addr=%h wdata=%h, required 1 1 1000 1000 dddddddd",
               snap[69], snap[68], snap[67:64], snap[63:32], snap[31:0]);
    else n_pass++;
    n_total++;
    if ({stable, busy} !== 2'b11)
      $display("FAIL sb_hold: got stable=%b busy=%b, required 1 1", stable, busy);
    else n_pass++;
    n_total++;
    if ({wb_valid_o, wb_en_o, ready_o, req_after} !== 4'b1010)
      $display("FAIL sb_done: got valid=%b en=%b ready=%b req=%b, required 1 0 1 0",
               wb_valid_o, wb_en_o, ready_o, req_after);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [69:0] snap;
    logic stable, busy, req_after;
    phys[0] = 32'h00800000;
    run_mem(mk(OP_LOAD, 3'b000, 5'd6), 32'h2002, $urandom, 0, 0, snap, stable, busy, req_after);
    n_total++;
    if ({snap[68:64], wb_valid_o, wb_en_o, wb_rd_o, wb_data_o} !==
        {1'b0, 4'b0100, 1'b1, 1'b1, 5'd6, 32'hFFFFFF80})
      $display("FAIL lb: got we=%b be=%b valid=%b en=%b rd=%0d data=%h, required 0 0100 1 1 6 ffffff80",
               snap[68], snap[67:64], wb_valid_o, wb_en_o, wb_rd_o, wb_data_o);
    else n_pass++;
    run_mem(mk(OP_LOAD, 3'b100, 5'd6), 32'h2002, $urandom, 1, 2, snap, stable, busy, req_after);
    n_total++;
    if (wb_data_o !== 32'h00000080)
      $display("FAIL lbu: got %h, required 00000080", wb_data_o);
    else n_pass++;
    phys[0] = 32'h8001FFFF;
    run_mem(mk(OP_LOAD, 3'b001, 5'd8), 32'h3002, $urandom, 2, 1, snap, stable, busy, req_after);
    n_total++;
    if ({snap[67:64], wb_data_o} !== {4'b1100, 32'hFFFF8001})
      $display("FAIL lh: got be=%b data=%h, required 1100 ffff8001", snap[67:64], wb_data_o);
    else n_pass++;
    phys[0] = 32'hDEADBEEF;
    run_mem(mk(OP_LOAD, 3'b010, 5'd10), 32'h5000, $urandom, 0, 5, snap, stable, busy,
            req_after);
    n_total++;
    if ({busy, wb_valid_o, wb_en_o, wb_data_o} !== {3'b111, 32'hDEADBEEF})
      $display("FAIL lw_wait: got busy=%b valid=%b en=%b data=%h, required 1 1 1 deadbeef",
               busy, wb_valid_o, wb_en_o, wb_data_o);
    else n_pass++;
    tick();
    n_total++;
    if (wb_valid_o !== 1'b0) $display("FAIL lw_pulse: got valid=%b, required 0", wb_valid_o);
    else n_pass++;
    run_mem(mk(OP_LOAD, 3'b010, 5'd0), 32'h5000, $urandom, 0, 0, snap, stable, busy, req_after);
    n_total++;
    if ({wb_valid_o, wb_en_o} !== 2'b10)
      $display("FAIL lw_x0: got valid=%b en=%b, required 1 0", wb_valid_o, wb_en_o);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    send(mk(OP_LOAD, 3'b010, 5'd11), 32'h4001, $urandom);
    n_total++;
    if ({misaligned_o, wb_valid_o, wb_en_o, mem_req_o, ready_o} !== 5'b11001)
      $display("FAIL lw_misaligned: got mis=%b valid=%b en=%b req=%b ready=%b, required 1 1 0 0 1",
               misaligned_o, wb_valid_o, wb_en_o, mem_req_o, ready_o);
    else n_pass++;
    send(mk(OP_STORE, 3'b001, 5'd12), 32'h4003, $urandom);
    n_total++;
    if ({misaligned_o, wb_valid_o, wb_en_o, mem_req_o, ready_o} !== 5'b11001)
      $display("FAIL sh_misaligned: got mis=%b valid=%b en=%b req=%b ready=%b, required 1 1 0 0 1",
               misaligned_o, wb_valid_o, wb_en_o, mem_req_o, ready_o);
    else n_pass++;
    tick();
    n_total++;
    if ({misaligned_o, wb_valid_o, mem_req_o} !== 3'b000)
      $display("FAIL misaligned_pulse: got mis=%b valid=%b req=%b, required 0 0 0",
               misaligned_o, wb_valid_o, mem_req_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    send(mk(OP_LOAD, 3'b010, 5'd9), 32'h6000, $urandom);
    #2 rstn_i = 1'b0;
    #1;
    n_total++;
    if ({mem_req_o, ready_o} !== 2'b01)
      $display("FAIL reset_in_req: got req=%b ready=%b, required 0 1", mem_req_o, ready_o);
    else n_pass++;
    tick();
    rstn_i = 1'b1;
    send(mk(OP_LOAD, 3'b010, 5'd9), 32'h6000, $urandom);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    #2 rstn_i = 1'b0;
    tick();
    rstn_i       = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h12345678;
    tick();
    mem_rvalid_i = 1'b0;
    n_total++;
    if ({wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, misaligned_o, ready_o} !== {39'h0, 1'b1})
      $display("FAIL stray_rvalid: got valid=%b en=%b rd=%0d data=%h mis=%b ready=%b, required 0 0 0 0 0 1",
               wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, misaligned_o, ready_o);
    else n_pass++;
    tick();
    n_total++;
    if ({wb_valid_o, mem_req_o} !== 2'b00)
      $display("FAIL stray_quiet: got valid=%b req=%b, required 0 0", wb_valid_o, mem_req_o);
    else n_pass++;
  endtask

  // Random instruction mix checked against a byte-addressed memory model.
  task automatic test_random();
    logic [69:0] snap;
    logic stable, busy, req_after;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] res, st, exp_wdata, exp_data;
    logic [3:0]  exp_be;
    logic [6:0]  ops[4];
    longint unsigned v;
    int kind, n, a, idx;
    bit sup;
    ops[0] = OP_ALU;
    ops[1] = OP_IMM;
    ops[2] = OP_BRANCH;
    ops[3] = OP_LUI;
    for (int i = 0; i < 16; i++) begin
      phys[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = phys[i][8*b +: 8];
    end
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom_range(0, 7));
      rd   = 5'($urandom_range(0, 31));
      st   = $urandom;
      res  = 32'h8000 + 32'($urandom_range(0, 63));
      if (kind < 3) op = ops[$urandom_range(0, 3)];
      else if (kind < 7) op = OP_LOAD;
      else op = OP_STORE;
      n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      a   = int'(res[1:0]);
      idx = int'(res[5:0]);
      if (op == OP_LOAD) sup = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) ||
                               (f3 == 3'd5);
      else if (op == OP_STORE) sup = (f3 <= 3'd2);
      else sup = 1'b0;
      if (!sup) begin
        send(mk(op, f3, rd), res, st);
        n_total++;
        if ({wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, misaligned_o, mem_req_o} !==
            {1'b1, (rd != 0) && op != OP_BRANCH && op != OP_LOAD && op != OP_STORE, rd, res,
             2'b00})
          $display("FAIL rnd_pass it=%0d: got valid=%b en=%b rd=%0d data=%h mis=%b req=%b, op=%b rd=%0d res=%h",
                   it, wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, misaligned_o, mem_req_o, op, rd,
                   res);
        else n_pass++;
      end else if ((a % n) != 0) begin
        send(mk(op, f3, rd), res, st);
        n_total++;
        if ({misaligned_o, wb_valid_o, wb_en_o, mem_req_o} !== 4'b1100)
          $display("FAIL rnd_misaligned it=%0d: got mis=%b valid=%b en=%b req=%b, required 1 1 0 0",
                   it, misaligned_o, wb_valid_o, wb_en_o, mem_req_o);
        else n_pass++;
      end else begin
        exp_be    = 4'(((1 << n) - 1) << a);
        exp_wdata = (n == 1) ? {24'h0, st[7:0]} * 32'h01010101 :
                    (n == 2) ? {16'h0, st[15:0]} * 32'h00010001 : st;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(ref_bytes[idx+i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
        exp_data = v[31:0];
        run_mem(mk(op, f3, rd), res, st, $urandom_range(0, 3), $urandom_range(0, 3), snap,
                stable, busy, req_after);
        n_total++;
        if ({snap[69:32], stable, busy, req_after} !==
            {1'b1, op == OP_STORE, exp_be, res & 32'hFFFFFFFC, 3'b110})
          $display("FAIL rnd_port it=%0d: got req=%b we=%b be=%b addr=%h stable=%b busy=%b req_end=%b, required be=%b addr=%h",
                   it, snap[69], snap[68], snap[67:64], snap[63:32], stable, busy, req_after,
                   exp_be, res & 32'hFFFFFFFC);
        else n_pass++;
        if (op == OP_STORE) begin
          // Only lanes with enables are compared; other lanes are don't-care.
          n_total++;
          if ((snap[31:0] & {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}}) !==
              (exp_wdata & {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}}) ||
              {wb_valid_o, wb_en_o} !== 2'b10)
            $display("FAIL rnd_store it=%0d: got wdata=%h valid=%b en=%b, required wdata=%h 1 0",
                     it, snap[31:0], wb_valid_o, wb_en_o, exp_wdata);
          else n_pass++;
          for (int i = 0; i < n; i++) ref_bytes[idx+i] = st[8*i +: 8];
        end else begin
          n_total++;
          if ({wb_valid_o, wb_en_o, wb_rd_o, wb_data_o} !== {1'b1, rd != 0, rd, exp_data})
            $display("FAIL rnd_load it=%0d: got valid=%b en=%b rd=%0d data=%h, required 1 %b %0d %h",
                     it, wb_valid_o, wb_en_o, wb_rd_o, wb_data_o, rd != 0, rd, exp_data);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rstn_i       = 1'b0;
    valid_i      = 1'b0;
    instr_i      = 32'h0;
    result_i     = 32'h0;
    rs2_i        = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    for (int i = 0; i < 16; i++) phys[i] = 32'h0;
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_store();
    test_load();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
